// File: rtl/simd_addsub_pipe.sv
// ---------------------------------------------------------------------------
// simd_addsub_pipe
//
// Pipelined SIMD lane adder/subtractor for the correlated-random generator
// datapath. Each accepted word is split into lanes of 8/16/32/64 bits. Each
// lane gets ADD, SUB, XOR or a 3-operand ADD, and a per-lane carry/borrow
// flag is produced. The byte-level carry chain is cut into STAGES registered
// segments. Segment k resolves bits [k*LEN/STAGES +: LEN/STAGES].
//
// Ports:
//   clk_i        clock, rising edge
//   rst_n_i      synchronous active-low reset
//   in_valid_i   input word valid
//   in_ready_o   unit accepts input this cycle (= ~out_valid_o | out_ready_i)
//   x_i, y_i     packed lane operands
//   ex_i         third operand, used only by ADD3 when EXTRA=1
//   mode_i       00 ADD, 01 SUB, 10 XOR, 11 ADD3
//   width_i      lane width 0=8, 1=16, 2=32, 3=64 bits
//   out_valid_o  result valid
//   out_ready_i  downstream accepts result
//   z_o          packed per-lane result
//   flag_o       per-byte flag; only the MSB byte of each lane can be set
// ---------------------------------------------------------------------------
module simd_addsub_pipe #(
  parameter int LEN    = 128,
  parameter int STAGES = 2,
  parameter int EXTRA  = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [LEN-1:0]   x_i,
  input  logic [LEN-1:0]   y_i,
  input  logic [LEN-1:0]   ex_i,
  input  logic [1:0]       mode_i,
  input  logic [1:0]       width_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [LEN-1:0]   z_o,
  output logic [LEN/8-1:0] flag_o
);

  localparam int NB    = LEN / 8;      // bytes per word
  localparam int SEG_B = NB / STAGES;  // bytes resolved per segment

  localparam logic [1:0] MODE_ADD  = 2'd0;
  localparam logic [1:0] MODE_SUB  = 2'd1;
  localparam logic [1:0] MODE_XOR  = 2'd2;
  localparam logic [1:0] MODE_ADD3 = 2'd3;

  // One pipeline slot. For bytes that are already resolved, sum holds the
  // final result and b is zero. For bytes that are not yet resolved, sum/b
  // are the partial-sum / shifted-carry pair that is still waiting for the
  // carry chain.
  typedef struct packed {
    logic            valid;
    logic [1:0]      mode;   // effective mode (ADD3 folded to ADD when EXTRA=0)
    logic [1:0]      width;
    logic            carry;  // carry out of the top byte of the last resolved segment
    logic [NB-1:0]   csa;    // CSA carry out of each byte's top bit (ADD3 flag source)
    logic [NB-1:0]   flag;
    logic [LEN-1:0]  sum;
    logic [LEN-1:0]  b;
  } stage_t;

  stage_t pipe_r [STAGES];
  stage_t next_s [STAGES];
  logic   adv_s;

  // True when byte idx is the least significant byte of its lane.
  function automatic logic lane_lsb(input int idx, input logic [1:0] w);
    int span;
    span = 32'sd1 << w;
    lane_lsb = ((idx & (span - 32'sd1)) == 32'sd0);
  endfunction

  // True when byte idx is the most significant byte of its lane.
  function automatic logic lane_msb(input int idx, input logic [1:0] w);
    int span;
    span = 32'sd1 << w;
    lane_msb = ((idx & (span - 32'sd1)) == (span - 32'sd1));
  endfunction

  // Turn the raw operands into a sum/b pair that one carry-propagate adder
  // can resolve. SUB becomes x + ~y, and the +1 is injected later at each
  // lane LSB. XOR forces b to zero so that no carry can ever be generated.
  // ADD3 runs a carry-save stage. Its carries shift up by one bit, and the
  // bit that would enter a lane's LSB from the lane below is dropped.
  function automatic stage_t prep(input logic v, input logic [1:0] m,
                                  input logic [1:0] w,
                                  input logic [LEN-1:0] x,
                                  input logic [LEN-1:0] y,
                                  input logic [LEN-1:0] e);
    stage_t         s;
    logic [LEN-1:0] maj;
    logic [LEN-1:0] lsb_bits;
    logic [1:0]     em;
    s        = '0;
    lsb_bits = '0;
    maj      = (x & y) | (x & e) | (y & e);
    for (int i = 0; i < NB; i++) begin
      lsb_bits[8*i] = lane_lsb(i, w);
    end
    if ((m == MODE_ADD3) && (EXTRA == 32'sd0)) begin
      em = MODE_ADD;
    end else begin
      em = m;
    end
    s.valid = v;
    s.mode  = em;
    s.width = w;
    case (em)
      MODE_ADD: begin
        s.sum = x;
        s.b   = y;
      end
      MODE_SUB: begin
        s.sum = x;
        s.b   = ~y;
      end
      MODE_ADD3: begin
        s.sum = x ^ y ^ e;
        s.b   = {maj[LEN-2:0], 1'b0} & ~lsb_bits;
        for (int i = 0; i < NB; i++) begin
          s.csa[i] = maj[8*i+7];
        end
      end
      default: begin
        s.sum = x ^ y;
        s.b   = '0;
      end
    endcase
    prep = s;
  endfunction

  // Resolve the bytes of segment seg. At a lane LSB the incoming carry is
  // replaced by the lane's carry-in: 1 for SUB, otherwise 0. This also masks
  // the inter-segment carry register whenever the segment boundary falls on
  // a lane boundary.
  function automatic stage_t resolve(input stage_t s_in, input int seg);
    stage_t     s;
    logic       c;
    logic [8:0] bs;
    int         i;
    s = s_in;
    c = s_in.carry;
    for (int j = 0; j < SEG_B; j++) begin
      i = seg * SEG_B + j;
      if (lane_lsb(i, s.width)) begin
        c = (s.mode == MODE_SUB);
      end else begin
        c = c;
      end
      bs = {1'b0, s.sum[8*i +: 8]} + {1'b0, s.b[8*i +: 8]} + {8'd0, c};
      s.sum[8*i +: 8] = bs[7:0];
      s.b[8*i +: 8]   = 8'd0;
      c               = bs[8];
      if (lane_msb(i, s.width)) begin
        case (s.mode)
          MODE_ADD:  s.flag[i] = c;
          MODE_SUB:  s.flag[i] = ~c;               // no carry out means x < y
          MODE_ADD3: s.flag[i] = c | s.csa[i];
          default:   s.flag[i] = 1'b0;
        endcase
      end else begin
        s.flag[i] = 1'b0;
      end
    end
    s.carry = c;
    resolve = s;
  endfunction

  // Global advance: every stage moves together unless the output is stalled.
  assign adv_s      = ~pipe_r[STAGES-1].valid | out_ready_i;
  assign in_ready_o = adv_s;

  // Next contents of each slot: segment k is resolved on entry to slot k.
  always_comb begin
    next_s[0] = resolve(prep(in_valid_i, mode_i, width_i, x_i, y_i, ex_i), 0);
    for (int k = 1; k < STAGES; k++) begin
      next_s[k] = resolve(pipe_r[k-1], k);
    end
  end

  // Pipeline registers: clear on reset, shift on advance, otherwise hold.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < STAGES; k++) begin
        pipe_r[k] <= '0;
      end
    end else if (adv_s) begin
      for (int k = 0; k < STAGES; k++) begin
        pipe_r[k] <= next_s[k];
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        pipe_r[k] <= pipe_r[k];
      end
    end
  end

  assign out_valid_o = pipe_r[STAGES-1].valid;
  assign z_o         = pipe_r[STAGES-1].sum;
  assign flag_o      = pipe_r[STAGES-1].flag;

endmodule

// File: tb/tb_simd_addsub_pipe.sv
// ---------------------------------------------------------------------------
// Testbench for simd_addsub_pipe (LEN=128, STAGES=2). There are two instances
// that share all inputs: one with EXTRA=1 and one with EXTRA=0. A lane-level
// arithmetic model fills a scoreboard queue at every accept. A monitor
// process pops an entry and compares it at every output transfer. The
// monitor also checks the in_ready relation and output stability during
// stalls.
// ---------------------------------------------------------------------------
module tb_simd_addsub_pipe;

  localparam int LEN    = 128;
  localparam int STAGES = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [LEN-1:0]   xi, yi, exi;
  logic [1:0]       mode, width;
  logic             out_ready;
  logic             in_ready1, in_ready0;
  logic             out_valid1, out_valid0;
  logic [LEN-1:0]   z1, z0;
  logic [LEN/8-1:0] f1, f0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int rdy_mode = 0;   // 0: ready high, 1: pattern 1,0,0, 2: ready low

  typedef struct {
    logic [LEN-1:0]   z1;
    logic [LEN/8-1:0] f1;
    logic [LEN-1:0]   z0;
    logic [LEN/8-1:0] f0;
    int               acc;
    bit               chk;
  } exp_t;

  exp_t q[$];

  simd_addsub_pipe #(.LEN(LEN), .STAGES(STAGES), .EXTRA(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready1),
    .x_i(xi), .y_i(yi), .ex_i(exi), .mode_i(mode), .width_i(width),
    .out_valid_o(out_valid1), .out_ready_i(out_ready), .z_o(z1), .flag_o(f1)
  );

  simd_addsub_pipe #(.LEN(LEN), .STAGES(STAGES), .EXTRA(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready0),
    .x_i(xi), .y_i(yi), .ex_i(exi), .mode_i(mode), .width_i(width),
    .out_valid_o(out_valid0), .out_ready_i(out_ready), .z_o(z0), .flag_o(f0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [LEN-1:0] got, input logic [LEN-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Lane-level reference: plain integer arithmetic on each lane, mod 2^w.
  function automatic void model(input logic [1:0] m, input logic [1:0] w,
                                input logic [LEN-1:0] x, input logic [LEN-1:0] y,
                                input logic [LEN-1:0] e, input bit extra,
                                output logic [LEN-1:0] z, output logic [LEN/8-1:0] f);
    int lw, nl;
    logic [65:0] xv, yv, ev, s, msk, zl;
    logic [LEN-1:0] tx, ty, te, tz;
    bit fl;
    lw  = 8 << w;
    nl  = LEN / lw;
    msk = (66'd1 << lw) - 66'd1;
    z = '0;
    f = '0;
    for (int l = 0; l < nl; l++) begin
      tx = x >> (l * lw);
      ty = y >> (l * lw);
      te = e >> (l * lw);
      xv = {2'b00, tx[63:0]} & msk;
      yv = {2'b00, ty[63:0]} & msk;
      ev = {2'b00, te[63:0]} & msk;
      fl = 1'b0;
      case (m)
        2'd1: begin zl = (xv - yv) & msk; fl = (xv < yv); end
        2'd2: begin zl = xv ^ yv; fl = 1'b0; end
        2'd3: begin
          s  = extra ? (xv + yv + ev) : (xv + yv);
          zl = s & msk;
          fl = (s > msk);
        end
        default: begin s = xv + yv; zl = s & msk; fl = (s > msk); end
      endcase
      tz = '0;
      tz[63:0] = zl[63:0];
      z = z | (tz << (l * lw));
      f[l * (lw / 8) + lw / 8 - 1] = fl;
    end
  endfunction

  // Present one word and hold it until it is accepted. If push is set, the
  // expected result goes into the scoreboard when the word is accepted.
  task automatic send(input logic [1:0] m, input logic [1:0] w, input logic [LEN-1:0] x,
                      input logic [LEN-1:0] y, input logic [LEN-1:0] e, input bit push, input bit lat);
    exp_t ent;
    bit done;
    mode = m; width = w; xi = x; yi = y; exi = e; in_valid = 1'b1;
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (in_ready1) begin
        if (push) begin
          model(m, w, x, y, e, 1'b1, ent.z1, ent.f1);
          model(m, w, x, y, e, 1'b0, ent.z0, ent.f0);
          ent.acc = cyc + 1;
          ent.chk = lat;
          q.push_back(ent);
        end
        done = 1'b1;
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: in_ready never rose, got 0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit empty;
    empty = 1'b0;
    for (int t = 0; t < 1000 && !empty; t++) begin
      @(negedge clk);
      empty = (q.size() == 0);
    end
    chk("drain_queue_empty", LEN'(q.size()), '0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [LEN-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive out_ready one step after each rising edge.
  initial begin : ready_drv
    int pat;
    pat = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = ((pat % 3) == 0); pat++; end
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: at every output transfer, pop one entry and compare against it.
  initial begin : monitor
    exp_t e;
    bit prev_stall;
    logic [LEN-1:0] hold_z;
    logic [LEN/8-1:0] hold_f;
    prev_stall = 1'b0;
    hold_z = '0;
    hold_f = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        chk("in_ready_rel", LEN'(in_ready1), LEN'(!(out_valid1 && !out_ready)));
        chk("in_ready_x0", LEN'(in_ready0), LEN'(in_ready1));
        if (prev_stall) begin
          chk("stall_valid", LEN'(out_valid1), LEN'(1));
          chk("stall_z", z1, hold_z);
          chk("stall_flag", LEN'(f1), LEN'(hold_f));
        end
        if (out_valid1 && out_ready) begin
          if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_output: got z=%h expected no output", z1);
          end else begin
            e = q.pop_front();
            chk("z_extra1", z1, e.z1);
            chk("flag_extra1", LEN'(f1), LEN'(e.f1));
            chk("valid_extra0", LEN'(out_valid0), LEN'(1));
            chk("z_extra0", z0, e.z0);
            chk("flag_extra0", LEN'(f0), LEN'(e.f0));
            if (e.chk) chk("latency", LEN'(cyc - e.acc + 1), LEN'(STAGES));
          end
        end
        prev_stall = out_valid1 && !out_ready;
        hold_z = z1;
        hold_f = f1;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [LEN-1:0] ones, bff, b01, c5a, ca5;
    rst_n = 1'b0; in_valid = 1'b0; xi = '0; yi = '0; exi = '0; mode = 2'd0; width = 2'd0;
    ones = '1;
    bff  = {16{8'hFF}};
    b01  = {16{8'h01}};
    ca5  = {16{8'hA5}};
    c5a  = {16{8'h5A}};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", LEN'(out_valid1), '0);
    chk("rst_z", z1, '0);
    chk("rst_flag", LEN'(f1), '0);
    chk("rst_in_ready", LEN'(in_ready1), LEN'(1));
    chk("rst_out_valid_x0", LEN'(out_valid0), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Directed words with the output always ready.
    send(2'd0, 2'd0, bff, b01, '0, 1'b1, 1'b1);
    repeat (3) @(posedge clk); #1;
    send(2'd1, 2'd3, {64'd5, 64'd3}, {64'd3, 64'd5}, '0, 1'b1, 1'b1);
    send(2'd0, 2'd3, ones, b01, '0, 1'b1, 1'b1);
    send(2'd2, 2'd2, ca5, c5a, ones, 1'b1, 1'b1);
    send(2'd0, 2'd0, bff, b01, '0, 1'b1, 1'b1);
    send(2'd3, 2'd1, ones, ones, ones, 1'b1, 1'b1);
    send(2'd3, 2'd0, rnd128(), rnd128(), rnd128(), 1'b1, 1'b1);
    send(2'd1, 2'd0, '0, b01, '0, 1'b1, 1'b1);
    drain();

    // Random back-to-back words, output always ready.
    for (int n = 0; n < 60; n++) begin
      send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), rnd128(), rnd128(), rnd128(), 1'b1, 1'b1);
    end
    drain();

    // Backpressure: out_ready follows the 1,0,0 pattern.
    rdy_mode = 1;
    repeat (2) @(posedge clk); #1;
    for (int n = 0; n < 24; n++) begin
      send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), rnd128(), rnd128(), rnd128(), 1'b1, 1'b0);
    end
    rdy_mode = 0;
    drain();

    // Reset with two words in flight; neither word may ever emerge.
    rdy_mode = 2;
    repeat (3) @(posedge clk); #1;
    send(2'd0, 2'd0, rnd128(), rnd128(), '0, 1'b0, 1'b0);
    send(2'd1, 2'd2, rnd128(), rnd128(), '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", LEN'(out_valid1), '0);
    chk("post_rst_valid_x0", LEN'(out_valid0), '0);
    chk("post_rst_in_ready", LEN'(in_ready1), LEN'(1));
    rdy_mode = 0;
    repeat (2) @(posedge clk); #1;
    send(2'd0, 2'd1, bff, b01, '0, 1'b1, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/simd_addsub_pipe.md
Name: simd_addsub_pipe

Overview:
- Pipelined, parametrised SIMD lane arithmetic unit for the correlated-random generator datapath.
- Takes packed PRNG words x, y and optional ex, and computes per-lane ADD, SUB, XOR or 3-operand ADD at a runtime-selectable lane width.
- The carry chain is split across STAGES registered segments. Full valid/ready backpressure sits between the PRNG source and the share-packing stage.
- Also emits a per-lane carry/borrow flag.

Parameters:
- LEN, 128, total datapath width in bits; multiple of 64.
- STAGES, 2, pipeline depth = carry-chain segments; must divide LEN/8; 1..LEN/8.
- EXTRA, 1, 1 = ADD3 mode implemented (CSA in front of carry chain); 0 = ADD3 decodes as ADD with ex ignored.

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_n_i  in  1  reset, synchronous, active-low
- in_valid_i  in  1  input word valid
- in_ready_o  out  1  unit accepts input this cycle
- x_i  in  LEN  operand x, packed lanes
- y_i  in  LEN  operand y
- ex_i  in  LEN  third operand (ADD3 only)
- mode_i  in  2  00 ADD, 01 SUB, 10 XOR, 11 ADD3
- width_i  in  2  lane width: 0=8, 1=16, 2=32, 3=64 bits
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts result
- z_o  out  LEN  packed per-lane result
- flag_o  out  LEN/8  per-byte flag; only the MSB byte of each lane is meaningful, all other bits 0

Behaviour:
- Reset (rst_n_i=0 at a clock edge): all stage valids, out_valid_o, z_o and flag_o go to 0; in_ready_o=1 after reset. In-flight data is discarded; no partial result is emitted afterwards.
- Handshake:
  - Transfer occurs when valid and ready are both high.
  - Global advance `adv = ~out_valid_o | out_ready_i`; in_ready_o = adv, purely combinational from out_ready_i and state.
  - When adv=0, every stage holds. out_valid_o/z_o/flag_o remain stable until accepted.
  - Bubbles propagate: a stage with valid=0 is overwritten on adv.
- Latency: exactly STAGES cycles from accept to out_valid_o with no stall. Throughput: 1 word/cycle with out_ready_i held high.
- mode_i and width_i are captured with each word and travel down the pipe, so a per-word mode/width change is legal back-to-back.
- Arithmetic per lane of w bits, results mod 2^w:
  - ADD: z = x+y; flag = carry out of lane.
  - SUB: z = x + ~y + 1; flag = 1 iff x < y unsigned (borrow).
  - XOR: z = x^y; flag = 0; carry chain forced to zero.
  - ADD3 (EXTRA=1): CSA(x,y,ex) then carry chain; z = x+y+ex; flag = 1 iff the true sum ≥ 2^w (either carry source).
- Lane isolation:
  - Carries never cross a lane boundary, including across segment registers.
  - The inter-segment carry register is masked when the segment boundary coincides with a lane boundary for the captured width.
  - The +1 for SUB is injected at every lane LSB.
- Segment k (0..STAGES-1) resolves bits [k*LEN/STAGES +: LEN/STAGES]. Lower bits already resolved ride forward in registers; higher bits wait as partial-sum/shifted-carry pairs.
- ex_i is ignored except in ADD3 with EXTRA=1.
- Simultaneous accept and emit in one cycle is legal and keeps full throughput.

Test Plan:
- Reset then LEN=128, STAGES=2: ADD, width 0, x=all 0xFF bytes, y=all 0x01 bytes -> after 2 cycles z=0, flag_o=all 1s (every byte is a lane MSB).
- SUB, width 3, x lanes = {5, 3}, y lanes = {3, 5} -> z lanes {2, 0xFFFF_FFFF_FFFF_FFFE}; flag set only on the MSB byte of the second lane.
- XOR, width 2, x=0xA5 repeated, y=0x5A repeated -> z=all 0xFF, flag_o=0. Repeat with a carry-heavy ADD word immediately before and after -> no carry leakage into the XOR word.
- ADD3, EXTRA=1, width 1, each lane x=y=ex=0xFFFF -> each lane z=0xFFFD, flag=1. With EXTRA=0, same stimulus -> z=0xFFFE, flag=1.
- Backpressure: stream 8 words with out_ready_i toggling 1,0,0,1,... -> output order and values match the model, no loss or duplication, outputs stable while stalled, in_ready_o low exactly when out_valid_o=1 and out_ready_i=0.
- Pull rst_n_i low for 1 cycle with 2 words in flight -> out_valid_o=0 next cycle; neither word ever appears; a new word accepted after reset emerges after STAGES cycles.
